// File: rtl/add_init_pkg.sv
// Shared types and helpers for the full-adder transaction initiator.
// Holds the FSM state encoding, counter widths and the reference adder equations.
// Pure declarations: no logic, no latency, no flow control.
package add_init_pkg;

  localparam int LAT_W = 4;
  localparam int TXN_W = 16;
  localparam int ERR_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } init_state_e;

  // Expected adder sum for one vector.
  function automatic logic exp_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Expected adder carry-out (majority of the three inputs).
  function automatic logic exp_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // One step of the 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shifting left.
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/add_init_lfsr.sv
// 8-bit Fibonacci LFSR producing pseudo-random adder stimulus.
// Latency: q reflects load/step one cycle after they are asserted.
// No backpressure: load and step are single-cycle strobes, always accepted.
module add_init_lfsr
  import add_init_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  // A load that coincides with a step advances from the seed, so the seed
  // itself is the value consumed by the vector issued on that edge.
  logic [7:0] base;
  assign base = load ? seed : q;

  // LFSR register: reset and load both return to the seed value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= seed;
    end else if (load || step) begin
      q <= step ? lfsr_next(base) : base;
    end
  end

endmodule

// File: rtl/add_txn_initiator.sv
// Drives {a,b,c} vectors into a registered full adder and checks sum/carry, counting txns and errors.
// Latency: 2+DUT_LAT cycles per transaction; NUM_TXN*(2+DUT_LAT) cycles per run.
// No backpressure: start is accepted only in IDLE/DONE and ignored while busy. Build option: ADD_INIT_EXHAUSTIVE_EN.
module add_txn_initiator
  import add_init_pkg::*;
#(
  parameter int         NUM_TXN   = 16,
  parameter int         DUT_LAT   = 1,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic [TXN_W-1:0] txn_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  // WAIT counts DUT_LAT-1 down to 0; with DUT_LAT==0 WAIT is never entered.
  localparam logic [LAT_W-1:0] LAT_LOAD = (DUT_LAT > 0) ? LAT_W'(DUT_LAT - 1) : '0;
  localparam logic [TXN_W-1:0] LAST_CNT = TXN_W'(NUM_TXN);

  init_state_e      state;
  init_state_e      state_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic             sum_smp;
  logic             carry_smp;
  logic             accept_start;
  logic             enter_drive;
  logic             last_txn;
  logic             mismatch;
  logic [TXN_W-1:0] txn_inc;
  logic [2:0]       stim;

  assign accept_start = start && ((state == IDLE) || (state == DONE));
  assign txn_inc      = txn_cnt + 1'b1;
  assign last_txn     = (txn_inc == LAST_CNT);
  assign enter_drive  = accept_start || ((state == CHECK) && !last_txn);

  // The adder response is compared against the vector still held on a/b/c.
  assign mismatch = (sum_smp   != exp_sum(a, b, c)) ||
                    (carry_smp != exp_carry(a, b, c));

`ifdef ADD_INIT_EXHAUSTIVE_EN
  // Vector index follows the transaction count: 000,001,...,111 then wraps.
  assign stim = accept_start ? 3'b000 : txn_inc[2:0];
`else
  logic [7:0] lfsr_q;
  logic       lfsr_lockup;

  // The all-zero state is a lockup for this polynomial; reseed if it ever appears.
  assign lfsr_lockup = (lfsr_q == 8'h00);

  add_init_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (accept_start || lfsr_lockup),
    .step  (enter_drive),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // On an accepted start the LFSR is being reloaded, so use the seed directly.
  assign stim = accept_start ? LFSR_SEED[2:0] : lfsr_q[2:0];
`endif

  // Next-state selection for the drive/wait/check sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = DRIVE;
      DRIVE:      state_nxt = (DUT_LAT == 0) ? CHECK : WAIT;
      WAIT:       if (lat_cnt == '0) state_nxt = CHECK;
      CHECK:      state_nxt = last_txn ? DONE : DRIVE;
      default:    state_nxt = IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == DRIVE) || (state_nxt == WAIT) || (state_nxt == CHECK);
      done  <= (state_nxt == DONE);
    end
  end

  // Operands change only when a new vector is issued, so they stay stable through CHECK.
  always_ff @(posedge clk) begin
    if (!reset) begin
      {a, b, c} <= 3'b000;
    end else if (enter_drive) begin
      {a, b, c} <= stim;
    end
  end

  // Latency counter: loaded leaving DRIVE, counts down through WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_cnt <= '0;
    end else if (state == DRIVE) begin
      lat_cnt <= LAT_LOAD;
    end else if ((state == WAIT) && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // Capture the adder response on the edge entering CHECK, giving the adder
  // exactly DUT_LAT full cycles after the a/b/c register updates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_smp   <= 1'b0;
      carry_smp <= 1'b0;
    end else if (state_nxt == CHECK) begin
      sum_smp   <= sum;
      carry_smp <= carry;
    end
  end

  // Per-run transaction and saturating error counters, cleared on an accepted start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      txn_cnt <= '0;
      err_cnt <= '0;
    end else if (accept_start) begin
      txn_cnt <= '0;
      err_cnt <= '0;
    end else if (state == CHECK) begin
      txn_cnt <= txn_inc;
      if (mismatch && (err_cnt != {ERR_W{1'b1}})) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_add_txn_initiator.sv
// Self-checking bench for add_txn_initiator with four instances and behavioural adder models.
// Expected vectors and error counts come from a per-run model built from the adder equations.
// Build option: ADD_INIT_EXHAUSTIVE_EN selects the vector model used by the bench.
module tb_add_txn_initiator;

`ifdef ADD_INIT_EXHAUSTIVE_EN
  localparam bit EXH = 1'b1;
`else
  localparam bit EXH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] st = 4'b0000;
  logic [1:0] flt [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic a0, b0, c0, s0, y0, bz0, dn0; logic [15:0] tc0; logic [7:0] ec0;
  logic a1, b1, c1, s1, y1, bz1, dn1; logic [15:0] tc1; logic [7:0] ec1;
  logic a2, b2, c2, s2, y2, bz2, dn2; logic [15:0] tc2; logic [7:0] ec2;
  logic a3, b3, c3, s3, y3, bz3, dn3; logic [15:0] tc3; logic [7:0] ec3;

  add_txn_initiator #(.NUM_TXN(8), .DUT_LAT(1)) u0 (
    .clk(clk), .reset(reset), .start(st[0]), .a(a0), .b(b0), .c(c0), .sum(s0), .carry(y0),
    .busy(bz0), .done(dn0), .txn_cnt(tc0), .err_cnt(ec0));
  add_txn_initiator #(.NUM_TXN(300), .DUT_LAT(0)) u1 (
    .clk(clk), .reset(reset), .start(st[1]), .a(a1), .b(b1), .c(c1), .sum(s1), .carry(y1),
    .busy(bz1), .done(dn1), .txn_cnt(tc1), .err_cnt(ec1));
  add_txn_initiator #(.NUM_TXN(8), .DUT_LAT(3)) u2 (
    .clk(clk), .reset(reset), .start(st[2]), .a(a2), .b(b2), .c(c2), .sum(s2), .carry(y2),
    .busy(bz2), .done(dn2), .txn_cnt(tc2), .err_cnt(ec2));
  add_txn_initiator #(.NUM_TXN(8), .DUT_LAT(2)) u3 (
    .clk(clk), .reset(reset), .start(st[3]), .a(a3), .b(b3), .c(c3), .sum(s3), .carry(y3),
    .busy(bz3), .done(dn3), .txn_cnt(tc3), .err_cnt(ec3));

  // Adder response {sum,carry}; f=1 carry stuck at 0, f=2 sum inverted.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c, input logic [1:0] f);
    logic s, cy;
    s  = a ^ b ^ c;
    cy = (a & b) | (a & c) | (b & c);
    if (f == 2'd1) cy = 1'b0;
    if (f == 2'd2) s = ~s;
    return {s, cy};
  endfunction

  // u0: 1-register adder, u1: combinational, u2/u3: 3-register adders.
  logic [1:0] p0;
  logic [1:0] p2 [3];
  logic [1:0] p3 [3];
  logic [1:0] q1;
  always @(posedge clk) begin
    p0    <= fa(a0, b0, c0, flt[0]);
    p2[0] <= fa(a2, b2, c2, flt[2]); p2[1] <= p2[0]; p2[2] <= p2[1];
    p3[0] <= fa(a3, b3, c3, flt[3]); p3[1] <= p3[0]; p3[2] <= p3[1];
  end
  always_comb begin
    q1 = fa(a1, b1, c1, flt[1]);
    {s0, y0} = p0;
    {s1, y1} = q1;
    {s2, y2} = p2[2];
    {s3, y3} = p3[2];
  end

  // Indexable views of the instance outputs.
  logic        bz_v [4];
  logic        dn_v [4];
  logic [15:0] tc_v [4];
  logic [7:0]  ec_v [4];
  logic [2:0]  abc_v [4];
  always_comb begin
    bz_v[0] = bz0; dn_v[0] = dn0; tc_v[0] = tc0; ec_v[0] = ec0; abc_v[0] = {a0, b0, c0};
    bz_v[1] = bz1; dn_v[1] = dn1; tc_v[1] = tc1; ec_v[1] = ec1; abc_v[1] = {a1, b1, c1};
    bz_v[2] = bz2; dn_v[2] = dn2; tc_v[2] = tc2; ec_v[2] = ec2; abc_v[2] = {a2, b2, c2};
    bz_v[3] = bz3; dn_v[3] = dn3; tc_v[3] = tc3; ec_v[3] = ec3; abc_v[3] = {a3, b3, c3};
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // exp_err: >=0 exact value, -1 use model count, -2 require non-zero.
  typedef struct {
    int         k;
    int         n;
    int         lat;
    logic [1:0] f;
    int         poke;
    int         exp_busy;
    int         exp_txn;
    int         exp_err;
  } vec_t;

  // One full run on instance k, checked against the vector/error model.
  task automatic run(input int k, input int n, input int lat, input logic [1:0] f,
                     input int poke, input int exp_busy, input int exp_txn, input int exp_err);
    logic [2:0] exp_vec [$];
    logic [2:0] got_vec [$];
    logic [7:0] lq;
    logic [2:0] v;
    int         model_err;
    int         cyc;
    int         vbad;
    bit         got_done;

    flt[k] = f;
    lq = 8'hA5;
    model_err = 0;
    for (int i = 0; i < n; i++) begin
      v = EXH ? 3'(i) : lq[2:0];
      exp_vec.push_back(v);
      lq = {lq[6:0], lq[7] ^ lq[5] ^ lq[4] ^ lq[3]};
      if (fa(v[2], v[1], v[0], f) != fa(v[2], v[1], v[0], 2'd0)) model_err++;
    end
    if (model_err > 255) model_err = 255;

    @(negedge clk); st[k] = 1'b1;
    @(negedge clk); st[k] = 1'b0;
    chk($sformatf("restart_u%0d", k), {dn_v[k], bz_v[k]}, 2'b01);

    cyc = 0;
    got_done = 1'b0;
    for (int t = 0; t < exp_busy + 20; t++) begin
      if (bz_v[k]) begin
        if (cyc % (2 + lat) == 0) got_vec.push_back(abc_v[k]);
        cyc++;
      end
      if (dn_v[k]) begin
        got_done = 1'b1;
        break;
      end
      st[k] = (poke > 0) && (cyc == poke);
      @(negedge clk);
    end
    st[k] = 1'b0;

    chk($sformatf("done_u%0d", k), got_done, 1);
    chk($sformatf("busy_cycles_u%0d", k), cyc, exp_busy);
    chk($sformatf("txn_cnt_u%0d", k), tc_v[k], exp_txn);
    if (exp_err == -2)
      chk($sformatf("err_nonzero_u%0d", k), ec_v[k] != 8'd0, 1);
    else if (exp_err == -1)
      chk($sformatf("err_model_u%0d", k), ec_v[k], model_err);
    else
      chk($sformatf("err_cnt_u%0d", k), ec_v[k], exp_err);

    vbad = (got_vec.size() > exp_vec.size()) ? got_vec.size() - exp_vec.size()
                                             : exp_vec.size() - got_vec.size();
    for (int i = 0; i < got_vec.size() && i < exp_vec.size(); i++)
      if (got_vec[i] != exp_vec[i]) vbad++;
    chk($sformatf("vectors_u%0d", k), vbad, 0);

    repeat (3) @(negedge clk);
    chk($sformatf("done_hold_u%0d", k), dn_v[k] && !bz_v[k] && (tc_v[k] == 16'(exp_txn)), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    bit   any;
    int   k, lat, poke;

    for (int i = 0; i < 4; i++) flt[i] = 2'd0;

    tbl[0] = '{0,   8, 1, 2'd0,  0,  24,   8,   0};
    tbl[1] = '{0,   8, 1, 2'd1,  0,  24,   8,  -1};
    tbl[2] = '{0,   8, 1, 2'd0, 10,  24,   8,   0};
    tbl[3] = '{1, 300, 0, 2'd2,  0, 600, 300, 255};
    tbl[4] = '{2,   8, 3, 2'd0,  0,  40,   8,   0};
    tbl[5] = '{3,   8, 2, 2'd0,  0,  32,   8,  -2};

    // Reset held for three cycles, then idle with start low.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      any = 1'b0;
      for (int j = 0; j < 4; j++)
        any |= bz_v[j] | dn_v[j] | (tc_v[j] != 0) | (ec_v[j] != 0) | (abc_v[j] != 0);
      chk($sformatf("idle_outputs_c%0d", i), any, 0);
    end

    for (int i = 0; i < 6; i++)
      run(tbl[i].k, tbl[i].n, tbl[i].lat, tbl[i].f, tbl[i].poke,
          tbl[i].exp_busy, tbl[i].exp_txn, tbl[i].exp_err);

    // Randomized faults and stray start pulses on the matched-latency instances.
    for (int r = 0; r < 4; r++) begin
      k    = ($urandom_range(0, 1) == 0) ? 0 : 2;
      lat  = (k == 0) ? 1 : 3;
      poke = $urandom_range(1, 8 * (2 + lat) - 2);
      run(k, 8, lat, 2'($urandom_range(0, 2)), poke, 8 * (2 + lat), 8, -1);
    end

    // Reset asserted in the fifth cycle of a run abandons it without done.
    flt[0] = 2'd0;
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_txn", tc0, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_reset_busy", bz0, 0);
    chk("mid_reset_done", dn0, 0);
    chk("mid_reset_txn", tc0, 0);
    chk("mid_reset_err", ec0, 0);
    chk("mid_reset_abc", {a0, b0, c0}, 0);
    reset = 1'b1;
    any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any |= dn0 | bz0;
    end
    chk("post_reset_no_done", any, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
